// File: rtl/adder_seq_ctrl.sv
// Slice-serial sequencer driving one shared WIDTH-bit adder over WORDS slices, LSB first.
// Optional subtract mode is enabled with `define ADDSEQ_SUB_EN (adds the sub port).
module adder_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
`ifdef ADDSEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] q,
  output logic                   cout,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_q,
  input  logic                   add_cout
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic            carry_r;
  logic [IW-1:0]   idx_r;
  logic            busy_r;
  logic            done_r;
  logic            accept_s;
  logic            sub_s;
  logic [N-1:0]    b_cap_s;
  logic            carry_cap_s;

`ifdef ADDSEQ_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign busy     = busy_r;
  assign done     = done_r;

  // Operand conditioning at capture: subtract is a + ~b + 1.
  always_comb begin
    b_cap_s     = b;
    carry_cap_s = cin;
    if (sub_s) begin
      b_cap_s     = ~b;
      carry_cap_s = 1'b1;
    end else begin
      b_cap_s     = b;
      carry_cap_s = cin;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? RUN : IDLE;
      RUN:     state_nxt_s = (idx_r == IDX_LAST) ? DONE : RUN;
      DONE:    state_nxt_s = start ? RUN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Adder pin drive: the current slice while running, zero otherwise.
  always_comb begin
    add_a   = {WIDTH{1'b0}};
    add_b   = {WIDTH{1'b0}};
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_a   = a_r[idx_r*WIDTH +: WIDTH];
      add_b   = b_r[idx_r*WIDTH +: WIDTH];
      add_cin = carry_r;
    end else begin
      add_a   = {WIDTH{1'b0}};
      add_b   = {WIDTH{1'b0}};
      add_cin = 1'b0;
    end
  end

  // State, status flags, operand capture and slice-by-slice result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      q       <= {N{1'b0}};
      cout    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= b_cap_s;
        carry_r <= carry_cap_s;
        idx_r   <= {IW{1'b0}};
      end else if (state_r == RUN) begin
        q[idx_r*WIDTH +: WIDTH] <= add_q;
        carry_r                 <= add_cout;
        if (idx_r == IDX_LAST) begin
          cout  <= add_cout;
          idx_r <= {IW{1'b0}};
        end else begin
          idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

endmodule
